// File: rtl/joypad_serializer_pkg.sv
// Shared definitions for the NES joypad serializer: button bit positions,
// sequence lengths, Four Score signature bytes, FSM state type and the
// helper that assembles a port's serial sequence.
// Optional feature macro: JOYPAD_FOURSCORE_EN (four-player adapter mode).
package joypad_serializer_pkg;

    // Button bit positions inside each 8-bit button vector (active-high)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Sequence lengths for the plain pad and the Four Score adapter
    localparam int SEQ_LEN_BASE      = 8;
    localparam int SEQ_LEN_FOURSCORE = 24;

    // Four Score signature bytes, shifted out LSB first after the pads
    localparam logic [7:0] SIG_P1 = 8'h10;
    localparam logic [7:0] SIG_P2 = 8'h20;

`ifdef JOYPAD_FOURSCORE_EN
    localparam int SEQ_LEN = SEQ_LEN_FOURSCORE;
`else
    localparam int SEQ_LEN = SEQ_LEN_BASE;
`endif

    // Per-port shifter state
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

`ifdef JOYPAD_FOURSCORE_EN
    // First pad in bits 7:0, second pad in 15:8, signature in 23:16
    function automatic logic [SEQ_LEN-1:0] build_seq(input logic [7:0] first_pad,
                                                     input logic [7:0] second_pad,
                                                     input logic [7:0] signature);
        return {signature, second_pad, first_pad};
    endfunction
`else
    // Single pad: the sequence is just the button byte
    function automatic logic [SEQ_LEN-1:0] build_seq(input logic [7:0] first_pad);
        return first_pad;
    endfunction
`endif

endpackage

// File: rtl/joypad_serializer_if.sv
// CPU-side bus of the joypad serializer: strobe level, per-port read pulses,
// button inputs and the two serial data bits.
// Optional feature macro: JOYPAD_FOURSCORE_EN adds btn_p3/btn_p4.
interface joypad_serializer_if;

    logic       strobe;
    logic       rd_p1;
    logic       rd_p2;
    logic [7:0] btn_p1;
    logic [7:0] btn_p2;
`ifdef JOYPAD_FOURSCORE_EN
    logic [7:0] btn_p3;
    logic [7:0] btn_p4;
`endif
    logic       data_p1;
    logic       data_p2;

`ifdef JOYPAD_FOURSCORE_EN
    modport master (output strobe, rd_p1, rd_p2, btn_p1, btn_p2, btn_p3, btn_p4,
                    input  data_p1, data_p2);
    modport slave  (input  strobe, rd_p1, rd_p2, btn_p1, btn_p2, btn_p3, btn_p4,
                    output data_p1, data_p2);
`else
    modport master (output strobe, rd_p1, rd_p2, btn_p1, btn_p2,
                    input  data_p1, data_p2);
    modport slave  (input  strobe, rd_p1, rd_p2, btn_p1, btn_p2,
                    output data_p1, data_p2);
`endif

endinterface

// File: rtl/joypad_serializer_shifter.sv
// One controller port: parallel-load shift register, saturating read counter
// and the registered serial data bit.
// The bit currently on data_o is held in data_q; sr_q holds the bits that
// follow it, so a read moves sr_q[0] to data_o and shifts FILL_BIT in at the top.
// A read in the clk where strobe has just fallen (strobe_q still 1) is
// treated as a read while strobe is high: nothing shifts and nothing reloads.
module joypad_shifter
    import joypad_serializer_pkg::*;
#(
    parameter int   SEQ_LEN  = 8,
    parameter logic FILL_BIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strobe_i,
    input  logic               rd_i,
    input  logic [SEQ_LEN-1:0] seq_i,
    output logic               data_o
);

    localparam int             CW      = $clog2(SEQ_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SEQ_LEN);

    shift_state_e       state_q;
    logic [SEQ_LEN-1:0] sr_q;
    logic [CW-1:0]      cnt_q;
    logic               data_q;
    logic               strobe_q;

    logic [SEQ_LEN-1:0] sr_shift_d;
    logic [CW-1:0]      cnt_inc_d;
    logic               last_read_d;

    // Next shift-register contents and counter value for an accepted read
    always_comb begin
        sr_shift_d  = {FILL_BIT, sr_q[SEQ_LEN-1:1]};
        cnt_inc_d   = cnt_q + CW'(1'b1);
        last_read_d = 1'b0;
        if (cnt_inc_d == CNT_MAX) begin
            last_read_d = 1'b1;
        end else begin
            last_read_d = 1'b0;
        end
    end

    // Port FSM: reload while strobe high, shift on reads, saturate in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_DONE;
            sr_q     <= '0;
            cnt_q    <= CNT_MAX;
            data_q   <= FILL_BIT;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_i;
            if (strobe_i) begin
                state_q <= ST_LOAD;
                sr_q    <= {FILL_BIT, seq_i[SEQ_LEN-1:1]};
                cnt_q   <= '0;
                data_q  <= seq_i[BTN_A];
            end else if (strobe_q) begin
                // Falling-strobe clk: keep the latched sequence, ignore reads
                state_q <= ST_SHIFT;
            end else if (rd_i) begin
                case (state_q)
                    ST_LOAD, ST_SHIFT: begin
                        sr_q  <= sr_shift_d;
                        cnt_q <= cnt_inc_d;
                        if (last_read_d) begin
                            state_q <= ST_DONE;
                            data_q  <= FILL_BIT;
                        end else begin
                            state_q <= ST_SHIFT;
                            data_q  <= sr_q[0];
                        end
                    end
                    ST_DONE: begin
                        data_q <= FILL_BIT;
                    end
                    default: begin
                        state_q <= ST_DONE;
                        cnt_q   <= CNT_MAX;
                        data_q  <= FILL_BIT;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/joypad_serializer.sv
// NES joypad serializer top: builds each port's serial sequence from the
// button inputs and drives one joypad_shifter per port.
// Optional feature macro: JOYPAD_FOURSCORE_EN -- 24-bit sequences carrying a
// second pad and the Four Score signature byte on each port.
module joypad_serializer
    import joypad_serializer_pkg::*;
#(
    parameter logic FILL_BIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    joypad_serializer_if.slave   bus
);

    logic [SEQ_LEN-1:0] seq_p1_s;
    logic [SEQ_LEN-1:0] seq_p2_s;
    logic               data_p1_s;
    logic               data_p2_s;

    // Assemble the parallel sequence presented to each port's shifter
    always_comb begin
`ifdef JOYPAD_FOURSCORE_EN
        seq_p1_s = build_seq(bus.btn_p1, bus.btn_p3, SIG_P1);
        seq_p2_s = build_seq(bus.btn_p2, bus.btn_p4, SIG_P2);
`else
        seq_p1_s = build_seq(bus.btn_p1);
        seq_p2_s = build_seq(bus.btn_p2);
`endif
    end

    joypad_shifter #(
        .SEQ_LEN  (SEQ_LEN),
        .FILL_BIT (FILL_BIT)
    ) u_port1 (
        .clk      (clk),
        .rst_n    (resetn),
        .strobe_i (bus.strobe),
        .rd_i     (bus.rd_p1),
        .seq_i    (seq_p1_s),
        .data_o   (data_p1_s)
    );

    joypad_shifter #(
        .SEQ_LEN  (SEQ_LEN),
        .FILL_BIT (FILL_BIT)
    ) u_port2 (
        .clk      (clk),
        .rst_n    (resetn),
        .strobe_i (bus.strobe),
        .rd_i     (bus.rd_p2),
        .seq_i    (seq_p2_s),
        .data_o   (data_p2_s)
    );

    assign bus.data_p1 = data_p1_s;
    assign bus.data_p2 = data_p2_s;

endmodule

// File: tb/tb_joypad_serializer.sv
// Scoreboard bench for joypad_serializer. Stimulus pushes the bit the CPU
// should see into a per-port queue; the monitor pops and compares on every
// clk low phase in which that port's read pulse (or an explicit peek) is up.
module tb_joypad_serializer;

    logic clk;
    logic resetn;

    joypad_serializer_if jif ();

    joypad_serializer #(
        .FILL_BIT (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (jif)
    );

    typedef struct {
        string name;
        logic  exp;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    logic peek1  = 1'b0;
    logic peek2  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input int p, input logic e, input string n);
        exp_t t;
        t.name = n;
        t.exp  = e;
        if (p == 1) q1.push_back(t);
        else        q2.push_back(t);
    endtask

    task automatic check_one(input int p, input logic act);
        exp_t t;
        checks++;
        if ((p == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_sample_p%0d: data=%b with nothing expected", p, act);
        end else begin
            if (p == 1) t = q1.pop_front();
            else        t = q2.pop_front();
            if (act !== t.exp) begin
                errors++;
                $display("FAIL %s: data_p%0d=%b, expected %b", t.name, p, act, t.exp);
            end
        end
    endtask

    // Monitor: compare the CPU-visible bit whenever a port is being read
    always @(negedge clk) begin
        if (jif.rd_p1 || peek1) check_one(1, jif.data_p1);
        if (jif.rd_p2 || peek2) check_one(2, jif.data_p2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic do1, input logic e1, input logic do2,
                        input logic e2, input string n);
        jif.rd_p1 = do1;
        jif.rd_p2 = do2;
        if (do1) push(1, e1, n);
        if (do2) push(2, e2, n);
        tick();
        jif.rd_p1 = 1'b0;
        jif.rd_p2 = 1'b0;
        tick();
    endtask

    task automatic peek(input int p, input logic e, input string n);
        push(p, e, n);
        if (p == 1) peek1 = 1'b1;
        else        peek2 = 1'b1;
        @(negedge clk);
        #1;
        peek1 = 1'b0;
        peek2 = 1'b0;
    endtask

    task automatic latch(input logic [7:0] b1, input logic [7:0] b2);
        jif.btn_p1 = b1;
        jif.btn_p2 = b2;
        jif.strobe = 1'b1;
        tick();
        jif.strobe = 1'b0;
        tick();
    endtask

    logic [11:0] e28;
`ifdef JOYPAD_FOURSCORE_EN
    logic [23:0] v1;
    logic [23:0] v2;
`endif

    initial begin
        resetn     = 1'b0;
        jif.strobe = 1'b0;
        jif.rd_p1  = 1'b0;
        jif.rd_p2  = 1'b0;
        jif.btn_p1 = 8'h00;
        jif.btn_p2 = 8'h00;
`ifdef JOYPAD_FOURSCORE_EN
        jif.btn_p3 = 8'hFF;
        jif.btn_p4 = 8'hFF;
`endif

        // Reset state: both data bits at FILL_BIT, counters saturated
        peek(1, 1'b1, "reset_data_p1");
        peek(2, 1'b1, "reset_data_p2");
        tick();
        resetn = 1'b1;
        tick();
        read(1'b1, 1'b1, 1'b1, 1'b1, "done_after_reset");

        // Start+A pressed: 1,0,0,1,0,0,0,0 then fill bits
        latch(8'h09, 8'h00);
        e28 = 12'b1111_0000_1001;
        for (int i = 0; i < 12; i++)
            read(1'b1, e28[i], 1'b0, 1'b0, $sformatf("seq09_read%0d", i + 1));

        // Strobe held high: data follows A every clk, reads do not shift
        jif.btn_p1 = 8'h01;
        jif.strobe = 1'b1;
        tick();
        jif.rd_p1  = 1'b1;
        jif.btn_p1 = 8'h02; push(1, 1'b1, "strobe_track1"); tick();
        jif.btn_p1 = 8'h01; push(1, 1'b0, "strobe_track2"); tick();
        jif.btn_p1 = 8'h02; push(1, 1'b1, "strobe_track3"); tick();
        jif.rd_p1  = 1'b0;
        jif.strobe = 1'b0;
        tick();
        read(1'b1, 1'b0, 1'b0, 1'b0, "after_strobe_first_is_A");
        read(1'b1, 1'b1, 1'b0, 1'b0, "after_strobe_second_is_B");

        // Read coinciding with strobe falling must not shift
        jif.btn_p1 = 8'h02;
        jif.strobe = 1'b1;
        tick();
        jif.strobe = 1'b0;
        read(1'b1, 1'b0, 1'b0, 1'b0, "coincident_read");
        read(1'b1, 1'b0, 1'b0, 1'b0, "coincident_no_shift");
        read(1'b1, 1'b1, 1'b0, 1'b0, "coincident_then_B");

        // Button changes after latching do not disturb the sequence
        latch(8'h00, 8'hFF);
        read(1'b0, 1'b0, 1'b1, 1'b1, "p2_latched_read1");
        read(1'b0, 1'b0, 1'b1, 1'b1, "p2_latched_read2");
        jif.btn_p2 = 8'h00;
        for (int i = 0; i < 7; i++)
            read(1'b0, 1'b0, 1'b1, 1'b1, $sformatf("p2_latched_read%0d", i + 3));
        latch(8'h00, 8'h00);
        read(1'b0, 1'b0, 1'b1, 1'b0, "p2_relatch_zero");

        // Simultaneous reads advance both ports in the same clk
        latch(8'h01, 8'h02);
        read(1'b1, 1'b1, 1'b1, 1'b0, "joint_read1");
        read(1'b1, 1'b0, 1'b1, 1'b1, "joint_read2");

`ifdef JOYPAD_FOURSCORE_EN
        // Four Score: pad, second pad, signature on each port
        jif.btn_p3 = 8'hFF;
        jif.btn_p4 = 8'hA5;
        latch(8'h09, 8'h00);
        v1 = {8'h10, 8'hFF, 8'h09};
        v2 = {8'h20, 8'hA5, 8'h00};
        for (int i = 0; i < 24; i++)
            read(1'b1, v1[i], 1'b1, v2[i], $sformatf("fourscore_bit%0d", i));
        read(1'b1, 1'b1, 1'b1, 1'b1, "fourscore_fill");
`endif

        // Asynchronous reset mid-sequence, then a clean reload
        latch(8'h06, 8'h00);
        read(1'b1, 1'b0, 1'b0, 1'b0, "prereset_read1");
        read(1'b1, 1'b1, 1'b0, 1'b0, "prereset_read2");
        read(1'b1, 1'b1, 1'b0, 1'b0, "prereset_read3");
        peek(1, 1'b0, "prereset_bit3");
        tick();
        resetn = 1'b0;
        peek(1, 1'b1, "reset_async_p1");
        tick();
        resetn = 1'b1;
        tick();
        read(1'b1, 1'b1, 1'b0, 1'b0, "post_reset_done_fill");
        latch(8'h06, 8'h00);
        read(1'b1, 1'b0, 1'b0, 1'b0, "post_reset_reload_A");

        // Drain anything the monitor has not consumed yet
        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++)
            @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0",
                     q1.size(), q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joypad_serializer.md
JOYPAD_SERIALIZER -- requirements
Module: joypad_serializer

Interface
REQ-001 SHALL have parameter FILL_BIT, default 1, meaning the bit value returned after the button sequence is exhausted.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port strobe, input, 1, the level of the CPU $4016 write bit 0.
REQ-005 SHALL have port rd_p1, input, 1, a one-clk pulse per CPU read of $4016.
REQ-006 SHALL have port rd_p2, input, 1, a one-clk pulse per CPU read of $4017.
REQ-007 SHALL have port btn_p1, input, 8, player-1 buttons, active-high: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-008 SHALL have port btn_p2, input, 8, player-2 buttons, same order.
REQ-009 SHALL have ports btn_p3 and btn_p4, input, 8 each, players 3/4, present only with JOYPAD_FOURSCORE_EN.
REQ-010 SHALL have port data_p1, output, 1, the registered serial bit presented on $4016 D0.
REQ-011 SHALL have port data_p2, output, 1, the registered serial bit presented on $4017 D0.

Function
REQ-012 Each port SHALL hold a shift register of SEQ_LEN bits (8 base, 24 with Four Score) and a read counter saturating at SEQ_LEN.
REQ-013 While strobe is 1, every clk SHALL reload the shift register from its sequence source, clear the counter, and drive data = bit0 of the source (A).
REQ-014 A read pulse while strobe is 1 SHALL neither shift nor advance the counter.
REQ-015 A read pulse while strobe is 0 SHALL shift right by one, filling with FILL_BIT, and increment the counter; data updates one clk after the pulse.
REQ-016 Once the counter reaches SEQ_LEN, data SHALL equal FILL_BIT on every further read; the counter SHALL not wrap.
REQ-017 rd_p1 and rd_p2 SHALL be independent; simultaneous pulses SHALL advance both ports in the same clk.
REQ-018 A read pulse coincident with a strobe 1->0 transition SHALL be treated as strobe still 1, with no shift.
REQ-019 Button changes while strobe is 0 SHALL not affect the bits already latched.
REQ-020 The states SHALL be LOAD (strobe=1), SHIFT (counter < SEQ_LEN) and DONE (counter = SEQ_LEN): LOAD->SHIFT on strobe low, SHIFT->DONE on the last read, any->LOAD on strobe high.

Reset
REQ-021 Asserting resetn low SHALL asynchronously clear the shift registers to 0, the counters to SEQ_LEN (DONE), and data_p1/data_p2 to FILL_BIT.
REQ-022 Reset mid-sequence SHALL discard the sequence; the next strobe high SHALL reload normally.
REQ-023 Reset deassertion SHALL take effect on the next clk edge with no extra delay.

Configuration
REQ-024 With JOYPAD_FOURSCORE_EN defined, SEQ_LEN SHALL be 24: port1 sends btn_p1, then btn_p3, then signature 8'h10 (LSB first); port2 sends btn_p2, then btn_p4, then signature 8'h20.
REQ-025 Without JOYPAD_FOURSCORE_EN, SEQ_LEN SHALL be 8, ports btn_p3/btn_p4 SHALL be absent, and no signature SHALL be sent.

Structure
REQ-026 A shared package SHALL hold the button bit-index constants, the SEQ_LEN values, and the signature constants 8'h10 and 8'h20.
REQ-027 A sub-module joypad_shifter (shift register, counter, data output; parameters SEQ_LEN and FILL_BIT) SHALL be instantiated once per port.

Verification
REQ-028 Bench SHALL check: btn_p1=8'b0000_1001, strobe 1->0, 8 rd_p1 pulses -> data_p1 sequence 1,0,0,1,0,0,0,0; reads 9-12 -> 1,1,1,1.
REQ-029 Bench SHALL check: strobe held 1, btn_p1 A toggles, 3 rd_p1 pulses -> data_p1 tracks A each clk; after strobe low, the first value is still A.
REQ-030 Bench SHALL check: strobe low, btn_p2=8'hFF, then btn_p2 changed to 8'h00 after 2 reads -> remaining 6 reads of data_p2 are all 1.
REQ-031 Bench SHALL check: rd_p1 and rd_p2 in the same clk with btn_p1=8'h01 and btn_p2=8'h02 -> after the first joint read, data_p1=0 and data_p2=1.
REQ-032 Bench SHALL check: with JOYPAD_FOURSCORE_EN, 24 reads of port1 -> bits 16..23 = 0,0,0,0,1,0,0,0, and port2 bits 16..23 = 0,0,0,0,0,1,0,0.
REQ-033 Bench SHALL check: resetn pulsed low after 3 reads -> data_p1=1 immediately, without waiting for a clk edge; the next strobe cycle yields the correct A bit.
